// File: rtl/rs_dec_pkg.sv
// Shared constants and state encoding for the RS(544,522) decoder error scheduler.
package rs_dec_pkg;

   localparam int unsigned LANES  = 32;  // Chien lanes per batch
   localparam int unsigned LANE_W = 5;   // log2(LANES)
   localparam int unsigned POS_W  = 10;  // symbol position width (0..543)
   localparam int unsigned T_MAX  = 11;  // correctable error limit
   localparam int unsigned CNT_W  = 5;   // saturating error counter width

   typedef enum logic [1:0] {
      StIdle,
      StDrain,
      StDone
   } sched_state_e;

endpackage

// File: rtl/forney_rr_pick.sv
// Rotating-priority finder: first set pending bit at or after the pointer, wrapping.
module forney_rr_pick
   import rs_dec_pkg::*;
(
   input  logic [LANES-1:0]  pending_i,
   input  logic [LANE_W-1:0] pointer_i,
   output logic [LANE_W-1:0] grant_o,
   output logic              any_o,
   output logic              single_o
);

   logic [LANE_W-1:0] idx;

   // Scan lanes starting at the pointer; first hit wins.
   always_comb begin
      grant_o = '0;
      any_o   = 1'b0;
      idx     = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         idx = pointer_i + LANE_W'(i);
         if (!any_o && pending_i[idx]) begin
            grant_o = idx;
            any_o   = 1'b1;
         end
      end
      // Exactly one bit set: non-zero and clearing the lowest bit leaves nothing.
      single_o = any_o && ((pending_i & (pending_i - LANES'(1))) == '0);
   end

endmodule

// File: rtl/forney_err_scheduler.sv
// Feeds Chien search hit batches into the shared Forney unit one error per cycle,
// counting errors per codeword and flagging uncorrectable codewords at the end.
module forney_err_scheduler
   import rs_dec_pkg::*;
(
   input  logic              clk_i,
   input  logic              srst,
   input  logic              en,
   input  logic              hit_valid_i,
   output logic              hit_ready_o,
   input  logic [LANES-1:0]  hit_vec_i,
   input  logic [POS_W-1:0]  hit_base_i,
   input  logic              hit_last_i,
   output logic              fy_valid_o,
   input  logic              fy_ready_i,
   output logic [LANE_W-1:0] fy_lane_o,
   output logic [POS_W-1:0]  fy_pos_o,
   output logic              fy_last_o,
   output logic              cw_done_o,
   output logic [CNT_W-1:0]  cw_err_cnt_o,
   output logic              cw_fail_o
);

   sched_state_e      state_q, state_d;
   logic [LANES-1:0]  pend_q, pend_d;
   logic [LANE_W-1:0] ptr_q, ptr_d;
   logic [POS_W-1:0]  base_q, base_d;
   logic              last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              fy_valid_q, fy_valid_d;
   logic [LANE_W-1:0] fy_lane_q, fy_lane_d;
   logic [POS_W-1:0]  fy_pos_q, fy_pos_d;
   logic              fy_last_q, fy_last_d;

   logic              accept;
   logic              hs;
   logic [LANE_W-1:0] pick_grant;
   logic              pick_any;
   logic              pick_single;

   assign hit_ready_o = !srst && en && (state_q == StIdle);
   assign accept      = hit_valid_i && hit_ready_o;
   assign hs          = fy_valid_q && fy_ready_i;

   // The picker looks at next-state pending/pointer so the following grant is
   // registered on the same edge as the handshake (one error per cycle).
   forney_rr_pick u_pick (
      .pending_i (pend_d),
      .pointer_i (ptr_d),
      .grant_o   (pick_grant),
      .any_o     (pick_any),
      .single_o  (pick_single)
   );

   // Control next state: batch latch, bit retirement, pointer and count updates.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      ptr_d   = ptr_q;
      base_d  = base_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (hit_vec_i != '0) begin
                  pend_d  = hit_vec_i;
                  base_d  = hit_base_i;
                  last_d  = hit_last_i;
                  state_d = StDrain;
               end else if (hit_last_i) begin
                  state_d = StDone;
               end
            end
         end
         StDrain: begin
            if (hs) begin
               pend_d = pend_q & ~(LANES'(1) << fy_lane_q);
               ptr_d  = fy_lane_q + LANE_W'(1);
               cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
               if (pend_d == '0) begin
                  state_d = last_q ? StDone : StIdle;
               end
            end
         end
         StDone: begin
            cnt_d   = '0;
            ptr_d   = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Request next state: hold a stalled request, otherwise launch a grant when enabled.
   always_comb begin
      fy_valid_d = fy_valid_q;
      fy_lane_d  = fy_lane_q;
      fy_pos_d   = fy_pos_q;
      fy_last_d  = fy_last_q;
      if (fy_valid_q && !fy_ready_i) begin
         fy_valid_d = 1'b1;
      end else if ((state_d == StDrain) && en && pick_any) begin
         fy_valid_d = 1'b1;
         fy_lane_d  = pick_grant;
         fy_pos_d   = base_d + POS_W'(pick_grant);
         fy_last_d  = last_d && pick_single;
      end else begin
         fy_valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (srst) begin
         state_q    <= StIdle;
         pend_q     <= '0;
         ptr_q      <= '0;
         base_q     <= '0;
         last_q     <= 1'b0;
         cnt_q      <= '0;
         fy_valid_q <= 1'b0;
         fy_lane_q  <= '0;
         fy_pos_q   <= '0;
         fy_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         ptr_q      <= ptr_d;
         base_q     <= base_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         fy_valid_q <= fy_valid_d;
         fy_lane_q  <= fy_lane_d;
         fy_pos_q   <= fy_pos_d;
         fy_last_q  <= fy_last_d;
      end
   end

   assign fy_valid_o = fy_valid_q;
   assign fy_lane_o  = fy_lane_q;
   assign fy_pos_o   = fy_pos_q;
   assign fy_last_o  = fy_last_q;

   // Codeword report is a decode of the one-cycle DONE state.
   assign cw_done_o    = (state_q == StDone);
   assign cw_err_cnt_o = cw_done_o ? cnt_q : '0;
   assign cw_fail_o    = cw_done_o && (cnt_q > CNT_W'(T_MAX));

endmodule

// File: tb/tb_forney_err_scheduler.sv
// Directed bench for forney_err_scheduler: table of batches plus hand sequences.
module tb_forney_err_scheduler;

   logic        clk = 1'b0;
   logic        srst;
   logic        en;
   logic        hit_valid;
   logic        hit_ready;
   logic [31:0] hit_vec;
   logic [9:0]  hit_base;
   logic        hit_last;
   logic        fy_valid;
   logic        fy_ready;
   logic [4:0]  fy_lane;
   logic [9:0]  fy_pos;
   logic        fy_last;
   logic        cw_done;
   logic [4:0]  cw_cnt;
   logic        cw_fail;

   int nchk = 0;
   int nerr = 0;

   forney_err_scheduler dut (
      .clk_i        (clk),
      .srst         (srst),
      .en           (en),
      .hit_valid_i  (hit_valid),
      .hit_ready_o  (hit_ready),
      .hit_vec_i    (hit_vec),
      .hit_base_i   (hit_base),
      .hit_last_i   (hit_last),
      .fy_valid_o   (fy_valid),
      .fy_ready_i   (fy_ready),
      .fy_lane_o    (fy_lane),
      .fy_pos_o     (fy_pos),
      .fy_last_o    (fy_last),
      .cw_done_o    (cw_done),
      .cw_err_cnt_o (cw_cnt),
      .cw_fail_o    (cw_fail)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   typedef struct packed {
      logic [31:0]      vec;
      logic [9:0]       base;
      logic             last;
      logic             stall;   // ready pattern 1,0,0,1,0,0...
      logic             ramp;    // expected lane k is simply k
      logic [7:0]       n;       // expected number of issued errors
      logic [7:0][4:0]  lanes;   // expected grant order
      logic [4:0]       cnt;     // expected count at codeword end
      logic             fail;
   } batch_t;

   function automatic batch_t mk(input logic [31:0] vec, input int base, input logic last,
                                 input logic stall, input int n, input int l0, input int l1,
                                 input int l2, input int l3, input int l4, input int l5,
                                 input int cnt, input logic fail);
      batch_t b;
      b = '0;
      b.vec = vec; b.base = 10'(base); b.last = last; b.stall = stall; b.ramp = 1'b0;
      b.n = 8'(n);
      b.lanes[0] = 5'(l0); b.lanes[1] = 5'(l1); b.lanes[2] = 5'(l2);
      b.lanes[3] = 5'(l3); b.lanes[4] = 5'(l4); b.lanes[5] = 5'(l5);
      b.cnt = 5'(cnt); b.fail = fail;
      return b;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one batch, drain it and check order, positions, last flag and the report.
   task automatic run_batch(input batch_t r);
      int         k;
      int         nobs;
      int         cyc_final;
      int         vcnt;
      bit         done_seen;
      bit         stall_prev;
      logic [4:0] held_lane;
      logic [9:0] held_pos;
      logic [4:0] exp_lane;
      hit_vec = r.vec; hit_base = r.base; hit_last = r.last; hit_valid = 1'b1;
      fy_ready = 1'b0;
      k = 0;
      while (!hit_ready && k < 50) begin
         step();
         k++;
      end
      chk("accept_ready", int'(hit_ready), 1);
      step();
      hit_valid = 1'b0;
      chk("launch_latency", int'(fy_valid), int'(r.n != 0));
      nobs = 0; vcnt = 0; done_seen = 0; stall_prev = 0;
      cyc_final = (r.n == 0) ? -1 : -100;
      held_lane = '0; held_pos = '0;
      for (int idx = 0; idx < 200; idx++) begin
         if (cw_done) begin
            chk("done_allowed", 1, int'(r.last && !done_seen));
            if (r.last && !done_seen) begin
               chk("done_cycle", idx, cyc_final + 1);
               chk("done_cnt", int'(cw_cnt), int'(r.cnt));
               chk("done_fail", int'(cw_fail), int'(r.fail));
            end
            done_seen = 1;
         end
         if (stall_prev) begin
            chk("stall_valid", int'(fy_valid), 1);
            chk("stall_lane", int'(fy_lane), int'(held_lane));
            chk("stall_pos", int'(fy_pos), int'(held_pos));
         end
         if (fy_valid) begin
            fy_ready = r.stall ? ((vcnt % 3) == 0) : 1'b1;
            vcnt++;
         end else begin
            fy_ready = 1'b0;
         end
         stall_prev = fy_valid && !fy_ready;
         held_lane = fy_lane;
         held_pos = fy_pos;
         if (fy_valid && fy_ready) begin
            exp_lane = r.ramp ? 5'(nobs) : ((nobs < 8) ? r.lanes[nobs] : 5'd0);
            chk("grant_lane", int'(fy_lane), int'(exp_lane));
            chk("grant_pos", int'(fy_pos), int'(r.base + 10'(exp_lane)));
            chk("grant_last", int'(fy_last), int'(r.last && (nobs == int'(r.n) - 1)));
            if (nobs == int'(r.n) - 1) cyc_final = idx;
            nobs++;
         end
         if (r.last ? done_seen : (nobs >= int'(r.n) && idx > cyc_final + 1)) break;
         step();
      end
      fy_ready = 1'b0;
      chk("issued_count", nobs, int'(r.n));
      if (r.last) begin
         chk("done_seen", int'(done_seen), 1);
         step();
         chk("done_one_cycle", int'(cw_done), 0);
      end
   endtask

   batch_t tbl [9];
   batch_t b;

   initial begin
      srst = 1'b1; en = 1'b1; hit_valid = 1'b0; hit_vec = '0; hit_base = '0;
      hit_last = 1'b0; fy_ready = 1'b0;

      //          vec           base last stall n  order             cnt fail
      tbl[0] = mk(32'h0000_0005, 100, 1, 0, 2, 0, 2, 0, 0, 0, 0,    2, 0);
      tbl[1] = mk(32'h0000_0010,   0, 0, 0, 1, 4, 0, 0, 0, 0, 0,    0, 0);
      tbl[2] = mk(32'h8000_0011, 200, 1, 0, 3, 31, 0, 4, 0, 0, 0,   4, 0);
      tbl[3] = mk(32'h0000_000F, 300, 1, 1, 4, 0, 1, 2, 3, 0, 0,    4, 0);
      tbl[4] = mk(32'h0000_003F,   0, 0, 0, 6, 0, 1, 2, 3, 4, 5,    0, 0);
      tbl[5] = mk(32'h0000_0FC0,  32, 1, 1, 6, 6, 7, 8, 9, 10, 11,  12, 1);
      tbl[6] = mk(32'h0000_0000,   0, 1, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0);
      tbl[7] = mk(32'h0000_0000,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0);
      tbl[8] = mk(32'h0000_0002,  10, 1, 0, 1, 1, 0, 0, 0, 0, 0,    1, 0);

      // Reset state, with en high so the ready gating by reset is visible.
      repeat (3) step();
      chk("rst_hit_ready", int'(hit_ready), 0);
      chk("rst_fy_valid", int'(fy_valid), 0);
      chk("rst_done", int'(cw_done), 0);
      chk("rst_cnt", int'(cw_cnt), 0);
      chk("rst_fail", int'(cw_fail), 0);
      srst = 1'b0;
      step();
      chk("idle_hit_ready", int'(hit_ready), 1);

      for (int i = 0; i < 9; i++) run_batch(tbl[i]);

      // Saturation: 40 hits over two batches, every hit still issued.
      b = mk(32'hFFFF_FFFF, 0, 0, 0, 32, 0, 0, 0, 0, 0, 0, 0, 0);
      b.ramp = 1'b1;
      run_batch(b);
      b = mk(32'h0000_00FF, 32, 1, 0, 8, 0, 0, 0, 0, 0, 0, 31, 1);
      b.ramp = 1'b1;
      run_batch(b);

      // en low mid-drain: presented request holds and completes, no new launch.
      hit_vec = 32'h0000_0003; hit_base = 10'd50; hit_last = 1'b1; hit_valid = 1'b1;
      fy_ready = 1'b0;
      step();
      hit_valid = 1'b0;
      chk("en_first_valid", int'(fy_valid), 1);
      chk("en_first_lane", int'(fy_lane), 0);
      en = 1'b0;
      step();
      chk("en_hold_valid", int'(fy_valid), 1);
      chk("en_hold_lane", int'(fy_lane), 0);
      fy_ready = 1'b1;
      step();
      chk("en_no_launch", int'(fy_valid), 0);
      chk("en_no_accept", int'(hit_ready), 0);
      step();
      chk("en_no_launch2", int'(fy_valid), 0);
      chk("en_no_done", int'(cw_done), 0);
      en = 1'b1;
      step();
      chk("en_resume_valid", int'(fy_valid), 1);
      chk("en_resume_lane", int'(fy_lane), 1);
      chk("en_resume_pos", int'(fy_pos), 51);
      chk("en_resume_last", int'(fy_last), 1);
      step();
      fy_ready = 1'b0;
      chk("en_done", int'(cw_done), 1);
      chk("en_done_cnt", int'(cw_cnt), 2);
      step();

      // srst mid-drain: request dropped, no done pulse, partial count discarded.
      hit_vec = 32'h0000_00F0; hit_base = 10'd0; hit_last = 1'b1; hit_valid = 1'b1;
      fy_ready = 1'b0;
      step();
      hit_valid = 1'b0;
      chk("srst_pre_valid", int'(fy_valid), 1);
      fy_ready = 1'b1;
      srst = 1'b1;
      step();
      srst = 1'b0;
      fy_ready = 1'b0;
      chk("srst_valid", int'(fy_valid), 0);
      chk("srst_done", int'(cw_done), 0);
      step();
      chk("srst_idle_ready", int'(hit_ready), 1);
      chk("srst_no_done", int'(cw_done), 0);
      run_batch(mk(32'h0000_0001, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
